// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder: one shared 4-bit adder slice, one nibble per clock, LSB nibble first.
// Optional subtract support is compiled in with the NSA_SUB_EN macro (adds the 'sub' port).

module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);
    localparam int STEPS = WIDTH / 4;
    localparam int IDX_W = $clog2(STEPS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_nx;
    logic [WIDTH-1:0]   a_reg, b_reg, b_in, sum_nx;
    logic [IDX_W-1:0]   idx;
    logic               carry, c_in, accept, last;
    logic [3:0]         nib_s;
    logic               nib_c;

    // Operand conditioning at the accept edge: subtract is A + ~B + 1.
    always_comb begin
        b_in = b;
        c_in = cin;
`ifdef NSA_SUB_EN
        if (sub) begin
            b_in = ~b;
            c_in = 1'b1;
        end
`endif
    end

    adder_4bit u_adder (
        .a   (a_reg[{idx, 2'b00} +: 4]),
        .b   (b_reg[{idx, 2'b00} +: 4]),
        .cin (carry),
        .s   (nib_s),
        .cout(nib_c)
    );

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state_q;
        accept   = 1'b0;
        last     = 1'b0;
        sum_nx   = sum;
        sum_nx[{idx, 2'b00} +: 4] = nib_s;
        unique case (state_q)
            IDLE: if (in_valid) begin
                accept   = 1'b1;
                state_nx = RUN;
            end
            RUN: if (idx == IDX_W'(STEPS - 1)) begin
                last     = 1'b1;
                state_nx = DONE;
            end
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            carry <= c_in;
        end else if (state_q == RUN) begin
            sum   <= sum_nx;
            carry <= nib_c;
            idx   <= last ? '0 : idx + 1'b1;
            if (last) begin
                flag_z <= (sum_nx == '0);
                flag_n <= sum_nx[WIDTH-1];
                flag_c <= nib_c;
                flag_v <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_nx[WIDTH-1] != a_reg[WIDTH-1]);
            end
        end
    end

    // NOTE: operand registers are pure datapath, only read after an accept loads them, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= a;
            b_reg <= b_in;
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl: directed vector table, hand-written
// multi-cycle sequences and random operands scored against an arithmetic reference model.

module tb_nibble_serial_add_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready, cin;
    logic [W-1:0] a, b;
    logic         sub_drv;
    logic         in_ready, out_valid, busy, flag_z, flag_n, flag_c, flag_v;
    logic [W-1:0] sum;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef NSA_SUB_EN
        .sub      (sub_drv),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .flag_c   (flag_c),
        .flag_v   (flag_v),
        .busy     (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        int           hold;
        logic [W-1:0] sum;
        logic [3:0]   znvc;  // {z, n, c, v}
    } vec_t;

    typedef struct packed {
        logic [W-1:0] sum;
        logic [3:0]   znvc;
    } res_t;

    // Reference: plain integer arithmetic; V is "signed result out of range".
    function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s);
        res_t   r;
        longint full, sfull;
        logic   c;
        if (s) begin
            full  = longint'(x) - longint'(y);
            sfull = longint'($signed(x)) - longint'($signed(y));
            c     = (x >= y);
        end else begin
            full  = longint'(x) + longint'(y) + longint'(ci);
            sfull = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
            c     = full[W];
        end
        r.sum  = full[W-1:0];
        r.znvc = {r.sum == '0, r.sum[W-1], c,
                  (sfull > longint'(2**(W-1) - 1)) || (sfull < -longint'(2**(W-1)))};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 20) begin tick(); cnt++; end
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        a = v.a; b = v.b; cin = v.cin; sub_drv = v.sub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_drv = 1'($urandom);
        cnt = 0;
        while (!out_valid && cnt < 20) begin tick(); cnt++; end
        check({tag, ".latency"}, 32'(cnt), 32'd4);
        check({tag, ".sum"}, 32'(sum), 32'(v.sum));
        check({tag, ".flags"}, 32'({flag_z, flag_n, flag_c, flag_v}), 32'(v.znvc));
        for (int h = 0; h < v.hold; h++) begin
            tick();
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_data"}, 32'({sum, flag_z, flag_n, flag_c, flag_v}), 32'({v.sum, v.znvc}));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".release"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        res_t r;
        int   cnt;

        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 4'b0000});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 4'b1010});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 3, 16'h8000, 4'b0101});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 0, 16'h0000, 4'b1011});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 0, 16'h0001, 4'b0000});
        vecs.push_back('{16'h0FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h1000, 4'b0000});
        vecs.push_back('{16'h000F, 16'h0000, 1'b1, 1'b0, 0, 16'h0010, 4'b0000});
`ifdef NSA_SUB_EN
        vecs.push_back('{16'h0003, 16'h0005, 1'b0, 1'b1, 0, 16'hFFFE, 4'b0100});
        vecs.push_back('{16'h0005, 16'h0005, 1'b1, 1'b1, 0, 16'h0000, 4'b1010});
`endif
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 16'hFFFF, 4'b0110});

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub_drv = 1'b0;
        a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset.ctrl", 32'({in_ready, out_valid, busy}), 32'b100);
        check("reset.data", 32'({sum, flag_z, flag_n, flag_c, flag_v}), 32'd0);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_ready", 32'({in_ready, out_valid, busy}), 32'b100);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Reset while the second nibble is in flight abandons the operation.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub_drv = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("midrun.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun.ctrl", 32'({in_ready, out_valid, busy}), 32'b100);
        check("midrun.data", 32'({sum, flag_z, flag_n, flag_c, flag_v}), 32'd0);
        tick();
        check("midrun.stay_idle", 32'(busy), 32'd0);

        // New operands held valid during RUN are ignored; out_ready early has no effect.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub_drv = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'hFFFF; b = 16'h0001; cin = 1'b1; out_ready = 1'b1;
        check("held.in_ready", 32'(in_ready), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin tick(); cnt++; end
        check("held.latency", 32'(cnt), 32'd4);
        check("held.sum", 32'(sum), 32'h3333);
        check("held.flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
        tick();
        check("held.release", 32'({in_ready, out_valid}), 32'b10);
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("held.idle_stable", 32'({busy, sum}), 32'h3333);

        for (int i = 0; i < 30; i++) begin
            v.a = W'($urandom); v.b = W'($urandom); v.cin = 1'($urandom);
`ifdef NSA_SUB_EN
            v.sub = 1'($urandom);
`else
            v.sub = 1'b0;
`endif
            v.hold = int'($urandom_range(0, 1));
            r = model(v.a, v.b, v.cin, v.sub);
            v.sum = r.sum; v.znvc = r.znvc;
            run_op(v, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
